// File: rtl/counter_arbiter_pkg.sv
// rtl/counter_arbiter_pkg.sv - shared types and round-robin pick for counter_arbiter
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NREQ_MAX = 8;
  localparam int PTR_W    = $clog2(NREQ_MAX);

  // First set request at or after ptr, wrapping modulo n; vector padded to NREQ_MAX.
  function automatic logic [NREQ_MAX-1:0] rr_pick(
    input logic [NREQ_MAX-1:0] req,
    input logic [PTR_W-1:0]    ptr,
    input int unsigned         n
  );
    logic [NREQ_MAX-1:0] g;
    logic [PTR_W-1:0]    idx;
    logic                found;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = PTR_W'((int'(ptr) + k) % int'(n));
      if (k < int'(n) && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// rtl/counter_arbiter_if.sv - requester-side bundle of the shared counter arbiter
interface counter_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic                  abort;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;

  modport master (
    output req, len, abort,
    input  gnt, done, busy, count
  );

  modport slave (
    input  req, len, abort,
    output gnt, done, busy, count
  );
endinterface

// File: rtl/shared_counter.sv
// rtl/shared_counter.sv - WIDTH-bit up-counter with clear (priority) and enable
module shared_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin time-sharing of one counter among NREQ requesters
module counter_arbiter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              reset,
  counter_arbiter_if.slave  bus
);

  state_t                    state_q;
  logic [NREQ-1:0]           gnt_q;
  logic [NREQ-1:0]           done_q;
  logic                      busy_q;
  logic [PTR_W-1:0]          ptr_q;
  logic [PTR_W-1:0]          owner_q;
  logic [WIDTH-1:0]          term_q;
  logic [WIDTH-1:0]          cnt;

  logic [NREQ_MAX-1:0]       req_ext;
  logic [NREQ_MAX*WIDTH-1:0] len_ext;
  logic [NREQ_MAX-1:0]       pick;
  logic [PTR_W-1:0]          win_idx;
  logic [WIDTH-1:0]          win_len;
  logic [PTR_W-1:0]          next_ptr;
  logic                      at_term;
  logic                      cnt_clr;
  logic                      cnt_en;

  always_comb begin
    req_ext                     = '0;
    req_ext[NREQ-1:0]           = bus.req;
    len_ext                     = '0;
    len_ext[NREQ*WIDTH-1:0]     = bus.len;
    pick                        = rr_pick(req_ext, ptr_q, NREQ);
    win_idx                     = '0;
    win_len                     = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (pick[i]) begin
        win_idx = PTR_W'(i);
        win_len = len_ext[i*WIDTH +: WIDTH];
      end
    end
  end

  assign next_ptr = PTR_W'((int'(owner_q) + 1) % NREQ);
  assign at_term  = (cnt == term_q);
  assign cnt_clr  = (state_q == IDLE) && (|bus.req);
  // Counting continues on an abort edge, so an aborted interval freezes one past the abort sample.
  assign cnt_en   = (state_q == RUN) && !at_term;

  shared_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
      term_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q <= RUN;
            gnt_q   <= pick[NREQ-1:0];
            busy_q  <= 1'b1;
            term_q  <= win_len;
            owner_q <= win_idx;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= next_ptr;
          end else if (at_term) begin
            state_q <= DONE;
            gnt_q   <= '0;
            done_q  <= gnt_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= next_ptr;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = cnt;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - scoreboard bench for counter_arbiter
module tb_counter_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  typedef struct {
    int owner;
    int len;
  } exp_t;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;
  int   gcyc;
  exp_t sb_q[$];

  counter_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  counter_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    bus.len[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic push_exp(input int owner, input int len);
    exp_t e;
    e.owner = owner;
    e.len   = len;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_count", 32'(bus.count), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Waits for n completions, dropping each finished requester's req on the following edge.
  task automatic serve(input int n, input int budget);
    logic [NREQ-1:0] d;
    bit              hit;
    for (int i = 0; i < n; i++) begin
      hit = 1'b0;
      d   = '0;
      for (int c = 0; c < budget && !hit; c++) begin
        @(negedge clk);
        if (bus.done != '0) begin
          hit = 1'b1;
          d   = bus.done;
        end
      end
      if (!hit) begin
        check("serve_timeout", 0, 1);
        return;
      end
      tick();
      bus.req = bus.req & ~d;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bus.gnt != '0) begin
        gcyc++;
        if (!$onehot(bus.gnt)) check("gnt_onehot", 32'(bus.gnt), 0);
      end else if (bus.done == '0) begin
        gcyc = 0;
      end
      if (bus.done != '0) begin
        if (sb_q.size() == 0) begin
          check("unexp_done", 32'(bus.done), 0);
        end else begin
          e = sb_q.pop_front();
          check("done_owner", 32'(bus.done), 32'(1) << e.owner);
          check("done_count", 32'(bus.count), 32'(e.len));
          check("gnt_cycles", 32'(gcyc), 32'(e.len + 1));
        end
        gcyc = 0;
      end
    end else begin
      gcyc = 0;
    end
  end

  initial begin
    n_total   = 0;
    n_bad     = 0;
    gcyc      = 0;
    reset     = 1'b0;
    bus.req   = '0;
    bus.len   = '0;
    bus.abort = 1'b0;
    do_reset();

    // single request, len 5
    set_len(1, 5);
    push_exp(1, 5);
    bus.req = 4'b0010;
    tick();
    check("s1_gnt", 32'(bus.gnt), 4'b0010);
    check("s1_busy", 32'(bus.busy), 1);
    check("s1_count0", 32'(bus.count), 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("s1_count", 32'(bus.count), 32'(k));
    end
    tick();
    check("s1_done", 32'(bus.done), 4'b0010);
    check("s1_gnt_low", 32'(bus.gnt), 0);
    check("s1_busy_done", 32'(bus.busy), 1);
    bus.req = '0;
    tick();
    check("s1_busy_low", 32'(bus.busy), 0);
    check("s1_hold", 32'(bus.count), 5);
    check("s1_done_low", 32'(bus.done), 0);
    tick();

    // contention from ptr=0
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_len(i, 2);
      push_exp(i, 2);
    end
    bus.req = 4'b1111;
    serve(4, 40);
    push_exp(0, 2);
    bus.req = 4'b0001;
    serve(1, 20);

    // fairness wrap: serve 2 so ptr=3, then 1001
    set_len(2, 1);
    push_exp(2, 1);
    bus.req = 4'b0100;
    serve(1, 20);
    set_len(3, 3);
    set_len(0, 1);
    push_exp(3, 3);
    push_exp(0, 1);
    bus.req = 4'b1001;
    serve(2, 40);

    // len=0 on requester 0
    set_len(0, 0);
    push_exp(0, 0);
    tick();
    bus.req = 4'b0001;
    tick();
    check("z_gnt", 32'(bus.gnt), 4'b0001);
    check("z_count", 32'(bus.count), 0);
    tick();
    check("z_done", 32'(bus.done), 4'b0001);
    check("z_gnt_low", 32'(bus.gnt), 0);
    bus.req = '0;
    tick();
    tick();

    // abort at count 3 of len 10, requester 2 waiting
    set_len(1, 10);
    set_len(2, 2);
    bus.req = 4'b0110;
    tick();
    check("ab_gnt", 32'(bus.gnt), 4'b0010);
    for (int k = 0; k < 3; k++) tick();
    check("ab_count3", 32'(bus.count), 3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.req   = 4'b0100;
    check("ab_gnt_low", 32'(bus.gnt), 0);
    check("ab_done_low", 32'(bus.done), 0);
    check("ab_busy", 32'(bus.busy), 0);
    check("ab_frozen", 32'(bus.count), 4);
    push_exp(2, 2);
    tick();
    check("ab_next", 32'(bus.gnt), 4'b0100);
    serve(1, 20);

    // abort coincident with count==term
    set_len(0, 2);
    bus.req = 4'b0001;
    tick();
    check("at_gnt", 32'(bus.gnt), 4'b0001);
    tick();
    tick();
    check("at_count", 32'(bus.count), 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.req   = '0;
    check("at_done", 32'(bus.done), 0);
    check("at_gnt_low", 32'(bus.gnt), 0);
    check("at_frozen", 32'(bus.count), 2);
    tick();
    check("at_done2", 32'(bus.done), 0);

    // async reset mid-RUN
    set_len(1, 20);
    bus.req = 4'b0010;
    tick();
    tick();
    tick();
    check("ar_busy_pre", 32'(bus.busy), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("ar_gnt", 32'(bus.gnt), 0);
    check("ar_done", 32'(bus.done), 0);
    check("ar_busy", 32'(bus.busy), 0);
    check("ar_count", 32'(bus.count), 0);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    set_len(2, 1);
    push_exp(2, 1);
    bus.req = 4'b0100;
    tick();
    check("ar_regrant", 32'(bus.gnt), 4'b0100);
    serve(1, 20);
    tick();
    tick();

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
